key_schedule_ctrl: RTL and testbench

- Sequential AES-128 key-expansion controller.
- Accepts one 128-bit cipher key, iterates the single-round key-expansion step once per clock for rounds 1..10, and stores all 11 round keys in an internal register file.
- Exposes a random-access read port so the round datapath (encrypt: index 0..10; decrypt: index 10..0) consumes keys without recomputation.
- Sits between the key-load interface and the cipher/decipher round datapath.

---
 rtl/aes_pkg.sv | 32 +++
 rtl/key_round_step.sv | 91 +++++++++
 rtl/key_schedule_ctrl.sv | 123 ++++++++++++
 tb/tb_key_schedule_ctrl.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared definitions for the AES-128 key-schedule controller:
// widths, round-key / round-index types, controller states and Rcon.
package aes_pkg;

    localparam int KEY_W      = 128;
    localparam int NUM_ROUNDS = 10;

    typedef logic [KEY_W-1:0] rkey_t;
    typedef logic [3:0]       ridx_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXPAND = 2'd1,
        DONE   = 2'd2
    } ks_state_e;

    localparam logic [7:0] RCON_TAB [0:9] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
        8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    // Round constant for expansion round rc (0-based); out-of-range gives 0.
    function automatic logic [7:0] rcon(input ridx_t rc);
        logic [7:0] r;
        r = 8'h00;
        if (rc <= 4'd9) begin
            r = RCON_TAB[rc];
        end
        return r;
    endfunction

endpackage

// File: rtl/key_round_step.sv
// One combinational AES-128 key-expansion round, plus the byte S-box it uses.
// The S-box is computed as GF(2^8) inverse (a^254) followed by the affine map,
// which keeps the netlist free of a 256-entry table literal.

module aes_sbox (
    input  logic [7:0] a,
    output logic [7:0] y
);

    function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] z);
        logic [7:0] p;
        logic [7:0] aa;
        logic [7:0] bb;
        p  = 8'h00;
        aa = x;
        bb = z;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) begin
                p = p ^ aa;
            end
            if (aa[7]) begin
                aa = {aa[6:0], 1'b0} ^ 8'h1b;
            end else begin
                aa = {aa[6:0], 1'b0};
            end
            bb = {1'b0, bb[7:1]};
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        logic [7:0] r;
        r = x;
        for (int i = 0; i < n; i++) begin
            r = {r[6:0], r[7]};
        end
        return r;
    endfunction

    logic [7:0] inv;

    // Multiplicative inverse as a^(2+4+...+128) = a^254; zero maps to zero.
    always_comb begin
        logic [7:0] sq;
        sq  = gmul(a, a);
        inv = sq;
        for (int i = 2; i < 8; i++) begin
            sq  = gmul(sq, sq);
            inv = gmul(inv, sq);
        end
        y = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end

endmodule

module key_round_step
    import aes_pkg::*;
(
    input  logic [3:0]   rc,
    input  logic [127:0] key_in,
    output logic [127:0] key_out
);

    logic [31:0] w0, w1, w2, w3;
    logic [31:0] rot_w;
    logic [31:0] sub_w;
    logic [31:0] t_w;
    logic [31:0] n0, n1, n2, n3;

    assign w0    = key_in[127:96];
    assign w1    = key_in[95:64];
    assign w2    = key_in[63:32];
    assign w3    = key_in[31:0];
    assign rot_w = {w3[23:0], w3[31:24]};

    aes_sbox u_sb0 (.a(rot_w[31:24]), .y(sub_w[31:24]));
    aes_sbox u_sb1 (.a(rot_w[23:16]), .y(sub_w[23:16]));
    aes_sbox u_sb2 (.a(rot_w[15:8]),  .y(sub_w[15:8]));
    aes_sbox u_sb3 (.a(rot_w[7:0]),   .y(sub_w[7:0]));

    // Mix in Rcon, then XOR-chain through the four words of the previous key.
    always_comb begin
        t_w     = sub_w ^ {rcon(rc), 24'h000000};
        n0      = w0 ^ t_w;
        n1      = w1 ^ n0;
        n2      = w2 ^ n1;
        n3      = w3 ^ n2;
        key_out = {n0, n1, n2, n3};
    end

endmodule

// File: rtl/key_schedule_ctrl.sv
// Sequential AES-128 key-expansion controller with an 11-entry round-key
// register file and a registered random-access read port.
// Optional build macro KEY_SCHED_ZEROIZE_EN adds a zeroize input that wipes
// all keys and returns the controller to IDLE.
module key_schedule_ctrl
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] key,
`ifdef KEY_SCHED_ZEROIZE_EN
    input  logic         zeroize,
`endif
    output logic         busy,
    output logic         keys_valid,
    input  logic [3:0]   rd_idx,
    output logic [127:0] rd_key
);

    ks_state_e state_q, state_d;
    ridx_t     cnt_q, cnt_d;
    logic      busy_q, busy_d;
    logic      kv_q, kv_d;
    rkey_t     rd_key_q, rd_key_d;
    rkey_t     rf_q [0:NUM_ROUNDS];
    rkey_t     rf_d [0:NUM_ROUNDS];
    rkey_t     step_in;
    rkey_t     step_out;
    ridx_t     cnt_nxt;
    logic      zero_req;

`ifdef KEY_SCHED_ZEROIZE_EN
    assign zero_req = zeroize;
`else
    assign zero_req = 1'b0;
`endif

    assign cnt_nxt = cnt_q + 4'd1;
    assign step_in = (cnt_q <= 4'(NUM_ROUNDS)) ? rf_q[cnt_q] : '0;

    // Single expansion engine, reused every EXPAND cycle on the previous entry.
    key_round_step u_step (
        .rc      (cnt_q),
        .key_in  (step_in),
        .key_out (step_out)
    );

    // Next-state, register-file write and read-port selection.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        kv_d     = kv_q;
        rf_d     = rf_q;
        rd_key_d = (rd_idx <= 4'(NUM_ROUNDS)) ? rf_q[rd_idx] : '0;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    rf_d[0] = key;
                    cnt_d   = 4'd0;
                    busy_d  = 1'b1;
                    kv_d    = 1'b0;
                    state_d = EXPAND;
                end
            end
            EXPAND: begin
                // Counter reaching NUM_ROUNDS means entry 10 is already stored.
                if (cnt_q == 4'(NUM_ROUNDS)) begin
                    busy_d  = 1'b0;
                    kv_d    = 1'b1;
                    state_d = DONE;
                end else begin
                    rf_d[cnt_nxt] = step_out;
                    cnt_d         = cnt_nxt;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (zero_req) begin
            for (int i = 0; i <= NUM_ROUNDS; i++) begin
                rf_d[i] = '0;
            end
            rd_key_d = '0;
            cnt_d    = 4'd0;
            busy_d   = 1'b0;
            kv_d     = 1'b0;
            state_d  = IDLE;
        end
    end

    // State and register-file update; reset clears everything including keys.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= 4'd0;
            busy_q   <= 1'b0;
            kv_q     <= 1'b0;
            rd_key_q <= '0;
            for (int i = 0; i <= NUM_ROUNDS; i++) begin
                rf_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            kv_q     <= kv_d;
            rd_key_q <= rd_key_d;
            for (int i = 0; i <= NUM_ROUNDS; i++) begin
                rf_q[i] <= rf_d[i];
            end
        end
    end

    assign busy       = busy_q;
    assign keys_valid = kv_q;
    assign rd_key     = rd_key_q;

endmodule

// File: tb/tb_key_schedule_ctrl.sv
// Scoreboard bench for key_schedule_ctrl: stimulus pushes expected busy,
// keys_valid and rd_key values tagged with the cycle they must appear in;
// a monitor on the falling edge pops and compares them.
module tb_key_schedule_ctrl;

    logic         clk;
    logic         rst;
    logic         start;
    logic [127:0] key;
    logic         busy;
    logic         keys_valid;
    logic [3:0]   rd_idx;
    logic [127:0] rd_key;
`ifdef KEY_SCHED_ZEROIZE_EN
    logic         zeroize;
`endif

    key_schedule_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .key        (key),
`ifdef KEY_SCHED_ZEROIZE_EN
        .zeroize    (zeroize),
`endif
        .busy       (busy),
        .keys_valid (keys_valid),
        .rd_idx     (rd_idx),
        .rd_key     (rd_key)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int           due;
        int           kind;   // 0 rd_key, 1 busy, 2 keys_valid
        logic [127:0] exp;
        string        name;
    } chk_t;

    chk_t q[$];
    int   total = 0;
    int   bad   = 0;

    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;

    // ---------------- reference model ----------------
    logic [7:0]   sbox [0:255];
    logic [127:0] cur  [0:10];   // register-file content the DUT should hold

    function automatic logic [7:0] rl(input logic [7:0] x, input int n);
        return (x << n) | (x >> (8 - n));
    endfunction

    task automatic build_sbox();
        logic [7:0] p;
        logic [7:0] qq;
        p  = 8'h01;
        qq = 8'h01;
        do begin
            p  = p ^ (p << 1) ^ ((p[7]) ? 8'h1b : 8'h00);
            qq = qq ^ (qq << 1);
            qq = qq ^ (qq << 2);
            qq = qq ^ (qq << 4);
            if (qq[7]) qq = qq ^ 8'h09;
            sbox[p] = qq ^ rl(qq, 1) ^ rl(qq, 2) ^ rl(qq, 3) ^ rl(qq, 4) ^ 8'h63;
        end while (p != 8'h01);
        sbox[0] = 8'h63;
    endtask

    function automatic logic [31:0] subword(input logic [31:0] w);
        return {sbox[w[31:24]], sbox[w[23:16]], sbox[w[15:8]], sbox[w[7:0]]};
    endfunction

    task automatic expand(input logic [127:0] k, output logic [127:0] rk [0:10]);
        logic [31:0] w [0:43];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t  = subword({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    // ---------------- scoreboard ----------------
    task automatic push(input int due, input int kind, input logic [127:0] exp, input string name);
        chk_t c;
        c.due  = due;
        c.kind = kind;
        c.exp  = exp;
        c.name = name;
        q.push_back(c);
    endtask

    always @(negedge clk) begin
        while (q.size() > 0 && q[0].due <= cyc) begin
            chk_t c;
            logic [127:0] act;
            c = q.pop_front();
            case (c.kind)
                0:       act = rd_key;
                1:       act = {127'b0, busy};
                default: act = {127'b0, keys_valid};
            endcase
            total++;
            if (c.due != cyc || act !== c.exp) begin
                bad++;
                $display("FAIL %s cyc=%0d due=%0d got=%h want=%h", c.name, cyc, c.due, act, c.exp);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic read_chk(input logic [3:0] idx, input logic [127:0] exp, input string name);
        rd_idx = idx;
        push(cyc + 1, 0, exp, name);
        tick();
    endtask

    task automatic read_all_model(input string name);
        for (int i = 0; i < 16; i++) begin
            read_chk(4'(i), (i > 10) ? 128'h0 : cur[i], name);
        end
    endtask

    // Start a schedule and follow it for 12 edges, checking busy/keys_valid timing
    // and random reads; a read of entry k returns the new key only after edge T+k.
    task automatic run_schedule(input logic [127:0] k, input int glitch_at, input logic [127:0] gk);
        logic [127:0] nw [0:10];
        int idx;
        expand(k, nw);
        start = 1'b1;
        key   = k;
        for (int i = 0; i < 12; i++) begin
            if (i == glitch_at) begin
                start = 1'b1;
                key   = gk;
            end else if (i > 0) begin
                start = 1'b0;
                key   = {$urandom, $urandom, $urandom, $urandom};
            end
            idx    = $urandom_range(0, 15);
            rd_idx = 4'(idx);
            push(cyc + 1, 0, (idx > 10) ? 128'h0 : ((i > idx) ? nw[idx] : cur[idx]), "rd_during_expand");
            push(cyc + 1, 1, {127'b0, (i < 11)}, "busy");
            push(cyc + 1, 2, {127'b0, (i == 11)}, "keys_valid");
            tick();
        end
        start = 1'b0;
        for (int r = 0; r < 11; r++) cur[r] = nw[r];
    endtask

    initial begin
        logic [127:0] rk;
        build_sbox();
        for (int r = 0; r < 11; r++) cur[r] = 128'h0;
        rst    = 1'b1;
        start  = 1'b0;
        key    = 128'h0;
        rd_idx = 4'd0;
`ifdef KEY_SCHED_ZEROIZE_EN
        zeroize = 1'b0;
`endif
        tick();
        tick();
        rst = 1'b0;
        push(cyc, 0, 128'h0, "reset_rd_key");
        push(cyc, 1, 128'h0, "reset_busy");
        push(cyc, 2, 128'h0, "reset_keys_valid");
        read_all_model("reset_read");

        // FIPS-197 key from IDLE
        run_schedule(FIPS_KEY, -1, 128'h0);
        read_chk(4'd0,  128'h2b7e151628aed2a6abf7158809cf4f3c, "fips_rk0");
        read_chk(4'd1,  128'ha0fafe1788542cb123a339392a6c7605, "fips_rk1");
        read_chk(4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, "fips_rk10");
        read_all_model("fips_model");

        // Rekey from DONE with the all-zero key
        run_schedule(128'h0, -1, 128'h0);
        read_chk(4'd1,  128'h62636363626363636263636362636363, "zero_rk1");
        read_chk(4'd10, 128'hb4ef5bcb3e92e21123e951cf6f8f188e, "zero_rk10");
        read_chk(4'd15, 128'h0, "zero_rk15");

        // start during EXPAND is ignored
        rk = {$urandom, $urandom, $urandom, $urandom};
        run_schedule(rk, 4, FIPS_KEY);
        read_all_model("glitch_model");

        // rst in the middle of an expansion
        start = 1'b1;
        key   = FIPS_KEY;
        for (int i = 0; i < 6; i++) begin
            push(cyc + 1, 1, 128'h1, "abort_busy");
            tick();
            start = 1'b0;
        end
        rst = 1'b1;
        push(cyc + 1, 0, 128'h0, "abort_rd_key");
        push(cyc + 1, 1, 128'h0, "abort_busy_clr");
        push(cyc + 1, 2, 128'h0, "abort_kv_clr");
        tick();
        rst = 1'b0;
        for (int r = 0; r < 11; r++) cur[r] = 128'h0;
        for (int i = 0; i < 14; i++) begin
            push(cyc + 1, 2, 128'h0, "abort_kv_stays0");
            read_chk(4'($urandom_range(0, 15)), 128'h0, "abort_read");
        end
        run_schedule(FIPS_KEY, -1, 128'h0);
        read_chk(4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, "post_abort_rk10");

        // Back-to-back random rekeys
        for (int n = 0; n < 3; n++) begin
            run_schedule({$urandom, $urandom, $urandom, $urandom}, -1, 128'h0);
            for (int j = 0; j < 6; j++) begin
                int idx;
                idx = $urandom_range(0, 15);
                read_chk(4'(idx), (idx > 10) ? 128'h0 : cur[idx], "random_read");
            end
        end

`ifdef KEY_SCHED_ZEROIZE_EN
        rd_idx  = 4'd10;
        zeroize = 1'b1;
        push(cyc + 1, 0, 128'h0, "zeroize_rd_key");
        push(cyc + 1, 1, 128'h0, "zeroize_busy");
        push(cyc + 1, 2, 128'h0, "zeroize_kv");
        tick();
        zeroize = 1'b0;
        for (int r = 0; r < 11; r++) cur[r] = 128'h0;
        read_all_model("zeroize_read");
        run_schedule(FIPS_KEY, -1, 128'h0);
        read_chk(4'd1, 128'ha0fafe1788542cb123a339392a6c7605, "post_zeroize_rk1");
`endif

        tick();
        tick();
        if (q.size() != 0) begin
            $display("FAIL scoreboard_drain left=%0d want=0", q.size());
            bad = bad + q.size();
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
